iter_shift_unit: RTL and testbench

ITER_SHIFT_UNIT -- requirements
Module: iter_shift_unit

---
 rtl/shift_pkg.sv | 26 ++
 rtl/shift_step.sv | 57 +++++
 rtl/iter_shift_unit.sv | 120 ++++++++++++
 tb/tb_iter_shift_unit.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared op-code and FSM state constants for the iterative shift unit.
// ITER_SHIFT_ROTATE_EN enables the ROR/ROL op codes.
package shift_pkg;

  // Operation codes
  localparam logic [2:0] OpSrl = 3'b000;
  localparam logic [2:0] OpSll = 3'b001;
  localparam logic [2:0] OpSra = 3'b010;
  localparam logic [2:0] OpRor = 3'b011;
  localparam logic [2:0] OpRol = 3'b100;

  // FSM state encoding
  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  // True when the op code is implemented in this build
  function automatic logic op_supported(input logic [2:0] op);
`ifdef ITER_SHIFT_ROTATE_EN
    return (op <= OpRol);
`else
    return (op <= OpSra);
`endif
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: shifts data by 0..Step positions and
// reports the last bit shifted out. Rotates exist only with ITER_SHIFT_ROTATE_EN.
module shift_step
  import shift_pkg::*;
#(
  parameter int unsigned Width = 16,
  parameter int unsigned Step  = 4,
  localparam int unsigned AmtW = $clog2(Step + 1)
) (
  input  logic [Width-1:0] data_i,
  input  logic [2:0]       op_i,
  input  logic [AmtW-1:0]  amt_i,
  output logic [Width-1:0] data_o,
  output logic             carry_o
);

  logic [Width-1:0] res_r, res_l, res_a;
  logic             c_r, c_l;

  // Extra bit below/above the operand catches the last bit shifted out
  assign {res_r, c_r} = {data_i, 1'b0} >> amt_i;
  assign {c_l, res_l} = {1'b0, data_i} << amt_i;
  assign res_a        = $unsigned($signed(data_i) >>> amt_i);

`ifdef ITER_SHIFT_ROTATE_EN
  logic [Width-1:0] res_ror, res_rol;
  // Shift by Width yields zero, so amt_i == 0 passes data through unchanged
  assign res_ror = (data_i >> amt_i) | (data_i << (Width - 32'(amt_i)));
  assign res_rol = (data_i << amt_i) | (data_i >> (Width - 32'(amt_i)));
`endif

  // Select result and carry for the requested op
  always_comb begin
    data_o  = data_i;
    carry_o = 1'b0;
    case (op_i)
      OpSrl: begin
        data_o  = res_r;
        carry_o = c_r;
      end
      OpSll: begin
        data_o  = res_l;
        carry_o = c_l;
      end
      OpSra: begin
        data_o  = res_a;
        carry_o = c_r;
      end
`ifdef ITER_SHIFT_ROTATE_EN
      OpRor: data_o = res_ror;
      OpRol: data_o = res_rol;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/iter_shift_unit.sv
// Iterative shifter: shifts up to STEP positions per cycle with a
// valid/ready request and result handshake. ITER_SHIFT_ROTATE_EN adds ROR/ROL.
module iter_shift_unit
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned STEP  = 4,
  localparam int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               RST,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               src_sel,
  input  logic [2:0]         op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   SHIFT_OUT,
  output logic               carry_out,
  output logic               op_err
);

  localparam int unsigned AMT_W = $clog2(STEP + 1);

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [2:0]         op_q, op_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic               carry_q, carry_d;
  logic               err_q, err_d;

  logic [AMT_W-1:0]   step_amt;
  logic [WIDTH-1:0]   step_data;
  logic               step_carry;

  // Shift by a full STEP until fewer than STEP positions remain
  assign step_amt = (32'(rem_q) >= STEP) ? AMT_W'(STEP) : AMT_W'(rem_q);

  shift_step #(
    .Width (WIDTH),
    .Step  (STEP)
  ) u_shift_step (
    .data_i  (data_q),
    .op_i    (op_q),
    .amt_i   (step_amt),
    .data_o  (step_data),
    .carry_o (step_carry)
  );

  // Next-state logic for the IDLE/SHIFT/DONE sequencer
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    op_d    = op_q;
    rem_d   = rem_q;
    carry_d = carry_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          data_d  = src_sel ? B : A;
          op_d    = op;
          rem_d   = shamt;
          carry_d = 1'b0;
          err_d   = 1'b0;
          if (!op_supported(op)) begin
            data_d  = '0;
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            state_d = (shamt != '0) ? StShift : StDone;
          end
        end
      end
      StShift: begin
        data_d  = step_data;
        carry_d = step_carry;
        rem_d   = rem_q - SHAMT_W'(step_amt);
        if (rem_q == SHAMT_W'(step_amt)) state_d = StDone;
      end
      StDone: begin
        // No accept here: in_ready is low until we are back in IDLE
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q <= StIdle;
      data_q  <= '0;
      op_q    <= '0;
      rem_q   <= '0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      carry_q <= carry_d;
      err_q   <= err_d;
    end
  end

  // Result outputs are zero except while a result is presented
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    SHIFT_OUT = out_valid ? data_q : '0;
    carry_out = out_valid & carry_q;
    op_err    = out_valid & err_q;
  end

endmodule

// File: tb/tb_iter_shift_unit.sv
// Directed self-checking bench for iter_shift_unit (WIDTH=16, STEP=4).
// Expectations for the rotate ops follow ITER_SHIFT_ROTATE_EN.
module tb_iter_shift_unit;

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] A = '0, B = '0;
  logic        src_sel = 1'b0;
  logic [2:0]  op = '0;
  logic [3:0]  shamt = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] SHIFT_OUT;
  logic        carry_out;
  logic        op_err;

  int n_chk  = 0;
  int n_fail = 0;

  iter_shift_unit #(
    .WIDTH (16),
    .STEP  (4)
  ) dut (
    .clk       (clk),
    .RST       (RST),
    .A         (A),
    .B         (B),
    .src_sel   (src_sel),
    .op        (op),
    .shamt     (shamt),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .SHIFT_OUT (SHIFT_OUT),
    .carry_out (carry_out),
    .op_err    (op_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request at a negedge, scramble inputs after accept, wait for the result,
  // check it, optionally hold it with out_ready low, then retire it.
  task automatic run_op(input string tag, input logic s, input logic [15:0] a,
                        input logic [15:0] b, input logic [2:0] o, input logic [3:0] sh,
                        input int exp_lat, input logic [15:0] exp_out, input logic exp_c,
                        input logic exp_e, input int hold);
    int lat;
    src_sel  = s;
    A        = a;
    B        = b;
    op       = o;
    shamt    = sh;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A        = 16'($urandom);
    B        = 16'($urandom);
    op       = 3'($urandom);
    shamt    = 4'($urandom);
    src_sel  = ~s;
    lat      = 0;
    while (lat < 30) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    chk({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "/out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "/SHIFT_OUT"}, 32'(SHIFT_OUT), 32'(exp_out));
    chk({tag, "/carry_out"}, 32'(carry_out), 32'(exp_c));
    chk({tag, "/op_err"}, 32'(op_err), 32'(exp_e));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "/hold"}, {13'd0, out_valid, in_ready, carry_out, SHIFT_OUT},
          {13'd0, 1'b1, 1'b0, exp_c, exp_out});
    end
    // Present a new request on the DONE exit edge; it must not be taken
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "/retire"}, {30'd0, in_ready, out_valid}, {30'd0, 1'b1, 1'b0});
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset", {12'd0, in_ready, out_valid, carry_out, op_err, SHIFT_OUT},
        {12'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000});
    RST = 1'b0;
    @(negedge clk);

    run_op("sll1",  1'b0, 16'h8001, 16'h0000, 3'b001, 4'd1,  2, 16'h0002, 1'b1, 1'b0, 0);
    run_op("sra9",  1'b1, 16'h5555, 16'hF000, 3'b010, 4'd9,  4, 16'hFFF8, 1'b0, 1'b0, 0);
`ifdef ITER_SHIFT_ROTATE_EN
    run_op("ror4",  1'b0, 16'h1234, 16'h0000, 3'b011, 4'd4,  2, 16'h4123, 1'b0, 1'b0, 0);
    run_op("rol4",  1'b0, 16'h1234, 16'h0000, 3'b100, 4'd4,  2, 16'h2341, 1'b0, 1'b0, 0);
`else
    run_op("ror4",  1'b0, 16'h1234, 16'h0000, 3'b011, 4'd4,  1, 16'h0000, 1'b0, 1'b1, 0);
    run_op("rol4",  1'b0, 16'h1234, 16'h0000, 3'b100, 4'd4,  1, 16'h0000, 1'b0, 1'b1, 0);
`endif
    run_op("srl0",  1'b0, 16'hABCD, 16'h0000, 3'b000, 4'd0,  1, 16'hABCD, 1'b0, 1'b0, 5);
    run_op("sll15", 1'b0, 16'h0003, 16'h0000, 3'b001, 4'd15, 5, 16'h8000, 1'b1, 1'b0, 0);
    run_op("srl7",  1'b1, 16'h0000, 16'hC0C0, 3'b000, 4'd7,  3, 16'h0181, 1'b1, 1'b0, 0);
    run_op("op111", 1'b0, 16'hFFFF, 16'hFFFF, 3'b111, 4'd3,  1, 16'h0000, 1'b0, 1'b1, 0);

    // Reset during a long shift: cycle T accepts, RST is high through cycle T+2
    src_sel  = 1'b0;
    A        = 16'h0001;
    op       = 3'b001;
    shamt    = 4'd15;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    RST = 1'b1;
    @(posedge clk);
    #1;
    RST = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("abort", {12'd0, in_ready, out_valid, carry_out, op_err, SHIFT_OUT},
          {12'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
